// File: rtl/uart_rx_sequence_checker.sv
// uart_rx_sequence_checker
//   UART receiver plus incrementing-pattern checker. It is the far-end partner of a test
//   transmitter that sends 0x00..0xFF repeatedly. Each good byte is presented with a
//   ready/ready_clr handshake. The byte is also compared against previous+1 (mod 256).
//   Frame and sequence errors are counted, and the low byte of the count drives LEDR.
//
// Optional feature:
//   UART_RX_EVEN_PARITY_EN  when defined, the frame is 8E1 (PARITY state between DATA and
//                           STOP). When undefined, the frame is 8N1.
//
// Ports:
//   clk_50m     in   system clock
//   clear       in   synchronous active-high reset
//   Rx          in   asynchronous serial line, idle high
//   ready_clr   in   consumer acknowledge; clears ready
//   data_out    out  last good byte received
//   ready       out  data_out holds an unacknowledged byte
//   overrun     out  sticky: good byte arrived while ready was set
//   frame_err   out  1-cycle pulse: bad stop bit (or bad parity)
//   seq_err     out  1-cycle pulse: good byte differs from expected value
//   locked      out  first good byte received since reset
//   err_count   out  frame_err + seq_err events, saturating
//   byte_count  out  good bytes received, wrapping
//   LEDR        out  err_count[7:0]
module uart_rx_sequence_checker #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk_50m,
    input  logic                 clear,
    input  logic                 Rx,
    input  logic                 ready_clr,
    output logic [7:0]           data_out,
    output logic                 ready,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          byte_count,
    output logic [7:0]           LEDR
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic                  rx_meta_q;
    logic                  rxs_q;
    logic [7:0]            data_q;
    logic                  ready_q;
    logic                  overrun_q;
    logic                  frame_err_q;
    logic                  seq_err_q;
    logic                  locked_q;
    logic [7:0]            expected_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [31:0]           byte_cnt_q;

    logic par_err;
`ifdef UART_RX_EVEN_PARITY_EN
    logic par_err_q;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    logic cnt_last;
    logic stop_sample;
    logic good_byte;
    logic bad_frame;
    logic seq_mismatch;
    logic err_inc;

    always_comb begin
        cnt_last     = (cnt_q == CntLast);
        stop_sample  = (state_q == StStop) && cnt_last;
        good_byte    = stop_sample && rxs_q && !par_err;
        // A parity failure is reported at the stop sample whatever the stop value.
        bad_frame    = stop_sample && (!rxs_q || par_err);
        seq_mismatch = good_byte && locked_q && (shift_q != expected_q);
        err_inc      = bad_frame || seq_mismatch;
    end

    always_ff @(posedge clk_50m) begin
        if (clear) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            data_q      <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            expected_q  <= '0;
            err_cnt_q   <= '0;
            byte_cnt_q  <= '0;
`ifdef UART_RX_EVEN_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= Rx;
            rxs_q       <= rx_meta_q;
            frame_err_q <= bad_frame;
            seq_err_q   <= seq_mismatch;

            // A new byte takes priority over an acknowledge in the same cycle.
            if (good_byte) begin
                data_q     <= shift_q;
                ready_q    <= 1'b1;
                byte_cnt_q <= byte_cnt_q + 32'd1;
                locked_q   <= 1'b1;
                expected_q <= shift_q + 8'd1;
                if (ready_q) begin
                    overrun_q <= 1'b1;
                end
            end else if (ready_clr) begin
                ready_q <= 1'b0;
            end

            if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rxs_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (!rxs_q) begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
`ifdef UART_RX_EVEN_PARITY_EN
                            par_err_q <= 1'b0;
`endif
                        end else begin
                            // Glitch shorter than half a bit: ignore silently.
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_last) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_EVEN_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`ifdef UART_RX_EVEN_PARITY_EN
                StParity: begin
                    if (cnt_last) begin
                        cnt_q     <= '0;
                        par_err_q <= ^{shift_q, rxs_q};
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`endif
                StStop: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= good_byte ? StIdle : StWaitHigh;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitHigh: begin
                    // Wait for the line to return high so a stuck-low line cannot retrigger.
                    cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign ready      = ready_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign seq_err    = seq_err_q;
    assign locked     = locked_q;
    assign err_count  = err_cnt_q;
    assign byte_count = byte_cnt_q;
    assign LEDR       = err_cnt_q[7:0];

endmodule

// File: tb/tb_uart_rx_sequence_checker.sv
// Directed bench for uart_rx_sequence_checker at 10 clocks per bit.
module tb_uart_rx_sequence_checker;

    localparam int unsigned CF  = 1000000;
    localparam int unsigned BR  = 100000;
    localparam int unsigned CPB = 10;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        rx = 1'b1;
    logic        ready_clr = 1'b0;
    logic [7:0]  data_out;
    logic        ready;
    logic        overrun;
    logic        frame_err;
    logic        seq_err;
    logic        locked;
    logic [7:0]  err_count;
    logic [31:0] byte_count;
    logic [7:0]  ledr;

    int total = 0;
    int bad   = 0;
    int n_frame = 0;
    int n_seq   = 0;

    uart_rx_sequence_checker #(
        .CLK_FREQ (CF),
        .BAUD_RATE(BR),
        .ERR_CNT_W(8)
    ) dut (
        .clk_50m   (clk),
        .clear     (clear),
        .Rx        (rx),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count),
        .byte_count(byte_count),
        .LEDR      (ledr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_frame++;
        if (seq_err) n_seq++;
    end

    task automatic apply_reset();
        @(negedge clk);
        clear = 1'b1;
        rx = 1'b1;
        ready_clr = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then the stop level held for extra cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB + hold) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data_out, ready, overrun, frame_err, seq_err, locked} !== 13'h0) begin
            bad++;
            $display("FAIL reset_flags got %h want 0",
                     {data_out, ready, overrun, frame_err, seq_err, locked});
        end
        total++;
        if (err_count !== 8'h00 || byte_count !== 32'h0 || ledr !== 8'h00) begin
            bad++;
            $display("FAIL reset_counts got err=%h bytes=%h led=%h want 0", err_count,
                     byte_count, ledr);
        end
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_incrementing();
        int s0;
        apply_reset();
        s0 = n_seq;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'(i), 1'b1, 0);
            total++;
            if (ready !== 1'b1 || data_out !== 8'(i)) begin
                bad++;
                $display("FAIL inc_byte%0d got ready=%b data=%h want 1 %h", i, ready, data_out,
                         8'(i));
            end
            pulse_clr();
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL inc_clr%0d got ready=%b want 0", i, ready);
            end
        end
        total++;
        if (locked !== 1'b1 || byte_count !== 32'd3 || err_count !== 8'd0 || n_seq != s0) begin
            bad++;
            $display("FAIL inc_final got locked=%b bytes=%0d err=%0d seq=%0d want 1 3 0 0",
                     locked, byte_count, err_count, n_seq - s0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        int s0;
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        apply_reset();
        s0 = n_seq;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b1, 0);
            total++;
            if (data_out !== seq[i]) begin
                bad++;
                $display("FAIL wrap_byte%0d got %h want %h", i, data_out, seq[i]);
            end
            pulse_clr();
        end
        total++;
        if (n_seq != s0 || byte_count !== 32'd4 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_final got seq=%0d bytes=%0d err=%0d want 0 4 0", n_seq - s0,
                     byte_count, err_count);
        end
    endtask

    task automatic test_seq_error();
        logic [7:0] seq [4];
        int exp_seq [4];
        int s0;
        seq = '{8'h10, 8'h11, 8'h20, 8'h21};
        exp_seq = '{0, 0, 1, 1};
        apply_reset();
        s0 = n_seq;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b1, 0);
            total++;
            if (data_out !== seq[i] || (n_seq - s0) != exp_seq[i]) begin
                bad++;
                $display("FAIL seqerr_byte%0d got data=%h seq=%0d want %h %0d", i, data_out,
                         n_seq - s0, seq[i], exp_seq[i]);
            end
            pulse_clr();
        end
        total++;
        if (err_count !== 8'd1 || ledr !== 8'h01) begin
            bad++;
            $display("FAIL seqerr_count got err=%0d led=%h want 1 01", err_count, ledr);
        end
    endtask

    task automatic test_frame_error();
        int f0;
        int s0;
        apply_reset();
        f0 = n_frame;
        s0 = n_seq;
        send_frame(8'hA5, 1'b0, 30);
        repeat (5) @(negedge clk);
        total++;
        if (n_frame - f0 != 1 || ready !== 1'b0 || byte_count !== 32'd0) begin
            bad++;
            $display("FAIL frame_bad got frames=%0d ready=%b bytes=%0d want 1 0 0",
                     n_frame - f0, ready, byte_count);
        end
        repeat (20) @(negedge clk);
        send_frame(8'h05, 1'b1, 0);
        total++;
        if (ready !== 1'b1 || data_out !== 8'h05) begin
            bad++;
            $display("FAIL frame_recover got ready=%b data=%h want 1 05", ready, data_out);
        end
        total++;
        if (n_frame - f0 != 1 || n_seq != s0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL frame_counts got frames=%0d seq=%0d err=%0d want 1 0 1",
                     n_frame - f0, n_seq - s0, err_count);
        end
        pulse_clr();
    endtask

    task automatic test_glitch_overrun();
        int f0;
        int s0;
        f0 = n_frame;
        s0 = n_seq;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (ready !== 1'b0 || n_frame != f0 || n_seq != s0 || byte_count !== 32'd1) begin
            bad++;
            $display("FAIL glitch got ready=%b frames=%0d seq=%0d bytes=%0d want 0 0 0 1",
                     ready, n_frame - f0, n_seq - s0, byte_count);
        end
        send_frame(8'h06, 1'b1, 0);
        total++;
        if (ready !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_first got ready=%b ovr=%b want 1 0", ready, overrun);
        end
        send_frame(8'h07, 1'b1, 0);
        total++;
        if (overrun !== 1'b1 || data_out !== 8'h07 || n_seq != s0 || byte_count !== 32'd3) begin
            bad++;
            $display("FAIL overrun_second got ovr=%b data=%h seq=%0d bytes=%0d want 1 07 0 3",
                     overrun, data_out, n_seq - s0, byte_count);
        end
    endtask

    task automatic test_mid_frame_reset();
        int f0;
        int s0;
        // Low through start and bits 0..3, into the middle of bit 4.
        rx = 1'b0;
        repeat (CPB * 5 + CPB / 2) @(negedge clk);
        clear = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({data_out, ready, overrun, frame_err, seq_err, locked} !== 13'h0 ||
            err_count !== 8'd0 || byte_count !== 32'd0 || ledr !== 8'd0) begin
            bad++;
            $display("FAIL midreset_zero got flags=%h err=%0d bytes=%0d want all 0",
                     {data_out, ready, overrun, frame_err, seq_err, locked}, err_count,
                     byte_count);
        end
        clear = 1'b0;
        repeat (20) @(negedge clk);
        f0 = n_frame;
        s0 = n_seq;
        send_frame(8'h33, 1'b1, 0);
        total++;
        if (data_out !== 8'h33 || ready !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL midreset_byte got data=%h ready=%b locked=%b want 33 1 1",
                     data_out, ready, locked);
        end
        total++;
        if (n_frame != f0 || n_seq != s0 || err_count !== 8'd0 || byte_count !== 32'd1) begin
            bad++;
            $display("FAIL midreset_counts got frames=%0d seq=%0d err=%0d bytes=%0d want 0 0 0 1",
                     n_frame - f0, n_seq - s0, err_count, byte_count);
        end
        pulse_clr();
    endtask

    // Seed with 0x00, then 256 more 0x00 bytes each mismatch; the 8-bit count must stop at 0xFF.
    task automatic test_saturate();
        int s0;
        apply_reset();
        s0 = n_seq;
        for (int i = 0; i < 257; i++) begin
            send_frame(8'h00, 1'b1, 0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (err_count !== 8'hFF || ledr !== 8'hFF) begin
            bad++;
            $display("FAIL saturate got err=%h led=%h want ff ff", err_count, ledr);
        end
        total++;
        if (n_seq - s0 != 256 || byte_count !== 32'd257 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL saturate_counts got seq=%0d bytes=%0d ovr=%b want 256 257 1",
                     n_seq - s0, byte_count, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_wrap();
        test_seq_error();
        test_frame_error();
        test_glitch_overrun();
        test_mid_frame_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
